// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state and key event record for the PS/2 key event path.
package ps2_pkg;

  localparam logic [7:0] SC_E0   = 8'hE0;
  localparam logic [7:0] SC_F0   = 8'hF0;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_ACK  = 8'hFA;
  localparam logic [7:0] SC_OVR0 = 8'h00;
  localparam logic [7:0] SC_OVR1 = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0
  } dec_state_e;

  typedef struct packed {
    logic       is_repeat;
    logic       ext;
    logic       make;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO of key events with a registered full flag.
module key_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  key_event_t wdata_i,
  input  logic       pop_i,
  output key_event_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

  key_event_t    mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head fields read zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DepthCnt);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_key_event.sv
// Decodes PS/2 scan bytes into make/break events, tracks the held key and counts new presses.
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_make,
  output logic             evt_repeat,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             overrun
);

  dec_state_e       state_q, state_d;
  logic             held_valid_q, held_valid_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             overrun_q, overrun_d;

  logic       fifo_full, fifo_empty;
  logic       accept, push;
  logic       held_match;
  key_event_t push_evt, head_evt;

  assign rx_ready = !fifo_full;
  assign accept   = rx_valid && !fifo_full;

  always_comb begin
    state_d       = state_q;
    held_valid_d  = held_valid_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    press_count_d = press_count_q;
    overrun_d     = overrun_q;
    push          = 1'b0;
    push_evt      = '0;
    push_evt.code = rx_data;
    push_evt.ext  = (state_q == StE0) || (state_q == StE0F0);
    push_evt.make = (state_q == StIdle) || (state_q == StE0);
    held_match    = held_valid_q && (held_code_q == rx_data) && (held_ext_q == push_evt.ext);

    if (accept) begin
      if (rx_data == SC_OVR0 || rx_data == SC_OVR1) begin
        overrun_d = 1'b1;
        state_d   = StIdle;
      end else if (rx_data == SC_E0) begin
        state_d = StE0;
      end else if (rx_data == SC_F0) begin
        // A second F0 after a break prefix is ignored and the prefix kept.
        case (state_q)
          StIdle:  state_d = StF0;
          StE0:    state_d = StE0F0;
          default: state_d = state_q;
        endcase
      end else if (state_q == StIdle && (rx_data == SC_BAT || rx_data == SC_ACK)) begin
        state_d = StIdle;
      end else begin
        state_d = StIdle;
        if (push_evt.make) begin
          if (held_match) begin
            push_evt.is_repeat = 1'b1;
            push               = REPEAT_EN;
          end else begin
            push          = 1'b1;
            held_valid_d  = 1'b1;
            held_code_d   = rx_data;
            held_ext_d    = push_evt.ext;
            press_count_d = press_count_q + 1'b1;
          end
        end else begin
          push = 1'b1;
          if (held_match) begin
            held_valid_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      held_valid_q  <= 1'b0;
      held_code_q   <= '0;
      held_ext_q    <= 1'b0;
      press_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_valid_q  <= held_valid_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      press_count_q <= press_count_d;
      overrun_q     <= overrun_d;
    end
  end

  key_evt_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (push_evt),
    .pop_i   (evt_ready),
    .rdata_o (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid   = !fifo_empty;
  assign evt_code    = head_evt.code;
  assign evt_ext     = head_evt.ext;
  assign evt_make    = head_evt.make;
  assign evt_repeat  = head_evt.is_repeat;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign held_ext    = held_ext_q;
  assign press_count = press_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Two instances (repeats suppressed / emitted) fed the same scan bytes, checked against a model.
module tb_ps2_key_event;

  localparam int Depth = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid    [2];
  logic       rx_ready    [2];
  logic       evt_valid   [2];
  logic       evt_ready;
  logic [7:0] evt_code    [2];
  logic       evt_ext     [2];
  logic       evt_make    [2];
  logic       evt_repeat  [2];
  logic       held_valid  [2];
  logic [7:0] held_code   [2];
  logic       held_ext    [2];
  logic [7:0] press_count [2];
  logic       overrun     [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ps2_key_event #(.FIFO_DEPTH(Depth), .REPEAT_EN(1'b0), .CNT_W(8)) u_dut0 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .evt_valid(evt_valid[0]), .evt_ready(evt_ready),
    .evt_code(evt_code[0]), .evt_ext(evt_ext[0]), .evt_make(evt_make[0]),
    .evt_repeat(evt_repeat[0]), .held_valid(held_valid[0]), .held_code(held_code[0]),
    .held_ext(held_ext[0]), .press_count(press_count[0]), .overrun(overrun[0])
  );

  ps2_key_event #(.FIFO_DEPTH(Depth), .REPEAT_EN(1'b1), .CNT_W(8)) u_dut1 (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .evt_valid(evt_valid[1]), .evt_ready(evt_ready),
    .evt_code(evt_code[1]), .evt_ext(evt_ext[1]), .evt_make(evt_make[1]),
    .evt_repeat(evt_repeat[1]), .held_valid(held_valid[1]), .held_code(held_code[1]),
    .held_ext(held_ext[1]), .press_count(press_count[1]), .overrun(overrun[1])
  );

  // Model: event packed as {repeat, ext, make, code}; prefix kept as two flags.
  logic [10:0] mq0[$], mq1[$], lg0[$], lg1[$], exp_q[$];
  bit          m_e0[2], m_f0[2], m_hv[2], m_hx[2], m_ovr[2];
  logic [7:0]  m_hc[2];
  int          m_cnt[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [10:0] mhead(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic void mpush(input int k, input logic [10:0] e);
    if (k == 0) mq0.push_back(e);
    else mq1.push_back(e);
  endfunction

  function automatic void mpop(input int k);
    if (k == 0) lg0.push_back(mq0.pop_front());
    else lg1.push_back(mq1.pop_front());
  endfunction

  function automatic void model_reset();
    mq0.delete(); mq1.delete(); lg0.delete(); lg1.delete();
    for (int k = 0; k < 2; k++) begin
      m_e0[k] = 0; m_f0[k] = 0; m_hv[k] = 0; m_hx[k] = 0; m_ovr[k] = 0;
      m_hc[k] = 8'h00; m_cnt[k] = 0;
    end
  endfunction

  function automatic void model_byte(input int k, input logic [7:0] b);
    bit ext, mk, same;
    if (b == 8'h00 || b == 8'hFF) begin
      m_ovr[k] = 1; m_e0[k] = 0; m_f0[k] = 0;
    end else if (b == 8'hE0) begin
      m_e0[k] = 1; m_f0[k] = 0;
    end else if (b == 8'hF0) begin
      m_f0[k] = 1;
    end else if (!m_e0[k] && !m_f0[k] && (b == 8'hAA || b == 8'hFA)) begin
      // status byte, no event
    end else begin
      ext = m_e0[k];
      mk = !m_f0[k];
      m_e0[k] = 0; m_f0[k] = 0;
      same = m_hv[k] && m_hc[k] == b && m_hx[k] == ext;
      if (mk && same) begin
        if (k == 1) mpush(k, {1'b1, ext, 1'b1, b});
      end else if (mk) begin
        mpush(k, {1'b0, ext, 1'b1, b});
        m_hv[k] = 1; m_hc[k] = b; m_hx[k] = ext; m_cnt[k]++;
      end else begin
        mpush(k, {1'b0, ext, 1'b0, b});
        if (same) m_hv[k] = 0;
      end
    end
  endfunction

  // Compare, then advance the model by the coming rising edge.
  always @(negedge clock) begin
    if (reset) model_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rx_ready%0d", k), rx_ready[k], msize(k) < Depth);
      check($sformatf("evt_valid%0d", k), evt_valid[k], msize(k) > 0);
      if (msize(k) > 0)
        check($sformatf("evt_head%0d", k),
              {evt_repeat[k], evt_ext[k], evt_make[k], evt_code[k]}, mhead(k));
      check($sformatf("held_valid%0d", k), held_valid[k], m_hv[k]);
      check($sformatf("held_code%0d", k), held_code[k], m_hc[k]);
      check($sformatf("held_ext%0d", k), held_ext[k], m_hx[k]);
      check($sformatf("press_count%0d", k), press_count[k], m_cnt[k] % 256);
      check($sformatf("overrun%0d", k), overrun[k], m_ovr[k]);
    end
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        bit acc, pop;
        acc = rx_valid[k] && (msize(k) < Depth);
        pop = evt_ready && (msize(k) > 0);
        if (pop) mpop(k);
        if (acc) model_byte(k, rx_data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    bit a0, a1;
    n = 0;
    rx_data = b;
    rx_valid[0] = 1'b1;
    rx_valid[1] = 1'b1;
    while ((rx_valid[0] || rx_valid[1]) && n < 40) begin
      @(negedge clock);
      a0 = rx_valid[0] && rx_ready[0];
      a1 = rx_valid[1] && rx_ready[1];
      @(posedge clock);
      #1;
      if (a0) rx_valid[0] = 1'b0;
      if (a1) rx_valid[1] = 1'b0;
      n++;
    end
    if (rx_valid[0] || rx_valid[1]) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: byte %0h not accepted (valid %0b%0b) required accept",
               b, rx_valid[1], rx_valid[0]);
      rx_valid[0] = 1'b0;
      rx_valid[1] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_count%0d", k), press_count[k], 0);
      check($sformatf("rst_evt%0d", k),
            {evt_valid[k], evt_repeat[k], evt_ext[k], evt_make[k], evt_code[k]}, 0);
    end
  endtask

  task automatic check_log(input int k, input string name);
    int n;
    n = (k == 0) ? lg0.size() : lg1.size();
    check($sformatf("%s_len%0d", name, k), n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_evt%0d_%0d", name, k, i), (k == 0) ? lg0[i] : lg1[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_data = 8'h00;
    rx_valid[0] = 1'b0;
    rx_valid[1] = 1'b0;
    evt_ready = 1'b1;
    model_reset();
    #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Plain make/break.
    do_reset();
    send(8'h1C);
    check("held_after_make", held_valid[0], 1);
    send(8'hF0); send(8'h1C);
    idle(4);
    exp_q = '{11'h11C, 11'h01C};
    check_log(0, "mkbrk"); check_log(1, "mkbrk");
    check("mkbrk_count", press_count[0], 1);
    check("mkbrk_held", held_valid[0], 0);

    // Extended key.
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    idle(4);
    exp_q = '{11'h375, 11'h275};
    check_log(0, "ext");
    check("ext_heldcode", held_code[0], 8'h75);

    // Typematic repeats.
    do_reset();
    send(8'h1B); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B);
    idle(4);
    exp_q = '{11'h11B, 11'h01B};
    check_log(0, "rep_off");
    exp_q = '{11'h11B, 11'h51B, 11'h51B, 11'h01B};
    check_log(1, "rep_on");
    check("rep_count0", press_count[0], 1);
    check("rep_count1", press_count[1], 1);

    // Backpressure: FIFO fills, fifth byte stalls until one pop.
    do_reset();
    evt_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    check("full_ready", rx_ready[0], 0);
    fork
      send(8'h2C);
      begin
        idle(5);
        check("stall_pending", rx_valid[0], 1);
        check("stall_ready", rx_ready[1], 0);
        evt_ready = 1'b1;
        idle(1);
        evt_ready = 1'b0;
      end
    join
    evt_ready = 1'b1;
    idle(8);
    exp_q = '{11'h115, 11'h11D, 11'h124, 11'h12D, 11'h12C};
    check_log(0, "full"); check_log(1, "full");
    check("full_count", press_count[0], 5);

    // Status and overrun bytes.
    do_reset();
    send(8'hAA); send(8'hFA); send(8'hFF); send(8'h1C);
    idle(6);
    exp_q = '{11'h11C};
    check_log(0, "filt");
    check("ovr_sticky", overrun[0], 1);
    do_reset();
    check("ovr_cleared", overrun[0], 0);

    // Reset discards a pending break prefix.
    send(8'hF0);
    do_reset();
    send(8'h1C);
    idle(4);
    exp_q = '{11'h11C};
    check_log(0, "rst_prefix");
    check("rst_prefix_count", press_count[0], 1);
    check("rst_prefix_held", held_valid[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
Consumes the raw byte stream from the PS/2 receiver and decodes it into key events: make or break, extended (E0) flag, and typematic-repeat flag. Decoded events are buffered in a small FIFO for the display/ASCII stage. The block also maintains the currently-held key and a key-press counter for the seven-segment display.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, >=2
REPEAT_EN, 0, 1 = emit typematic repeats as events with evt_repeat=1; 0 = suppress them
CNT_W, 8, width of press_count

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  8  scan byte from the PS/2 receiver
rx_valid  in  1  rx_data holds an unread byte
rx_ready  out  1  byte consumed this cycle when rx_valid&rx_ready (drives receiver read strobe)
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer pops head when evt_valid&evt_ready
evt_code  out  8  scan code of head event
evt_ext  out  1  head event was E0-prefixed
evt_make  out  1  1 = make, 0 = break
evt_repeat  out  1  head event is a typematic repeat
held_valid  out  1  a key is currently held
held_code  out  8  code of held key
held_ext  out  1  ext flag of held key
press_count  out  CNT_W  count of new (non-repeat) makes; wraps
overrun  out  1  sticky: receiver overrun byte (0x00 or 0xFF) seen

Behaviour:
- Reset is asynchronous and forces: state IDLE, FIFO empty, evt_valid=0, evt_* outputs=0, held_valid=0, held_code=0, held_ext=0, press_count=0, overrun=0.
- rx_ready = !fifo_full (registered full flag). Bytes arriving while the FIFO is full are never dropped; they wait on rx_valid.
- Decoder FSM states: IDLE, E0, F0, E0F0. The FSM updates only on an accepted byte b.
  - IDLE, b=E0 -> E0.
  - IDLE, b=F0 -> F0.
  - E0, b=F0 -> E0F0.
  - IDLE/E0, other b -> make(code=b, ext = state==E0) -> IDLE.
  - F0/E0F0, other b -> break(code=b, ext = state==E0F0) -> IDLE.
  - b=E0 in any state restarts at E0 (resync).
  - b=F0 in F0 or E0F0 is ignored; state is held.
- Filtered bytes in IDLE produce no event: 0xAA (self-test), 0xFA (ack). 0x00 and 0xFF are also filtered in any state, set overrun=1, and return the FSM to IDLE.
- Make handling:
  - If held_valid and code/ext equal held_code/held_ext, the make is a repeat: push an event with repeat=1 only if REPEAT_EN; press_count is unchanged.
  - Otherwise it is a new make: push the event, set held_valid=1, held_code/held_ext = code/ext, press_count += 1 (mod 2^CNT_W).
- Break handling: always push the event. If it matches the held key, held_valid=0; held_code/held_ext retain their last value. A break of a non-held key leaves the held state unchanged.
- Event latency: the byte accepted at edge N writes the FIFO at edge N; evt_valid is high from cycle N+1 when the FIFO was empty.
- FIFO is first-word-fall-through. A pop when empty is ignored.
- Simultaneous push and pop is allowed whenever not full; occupancy is unchanged.
- Full asserts at FIFO_DEPTH entries. Read/write pointers wrap modulo FIFO_DEPTH.
- A reset mid-sequence (for example after F0) discards the partial prefix and all buffered events.

Decomposition:
- ps2_pkg:
  - constants SC_E0=8'hE0, SC_F0=8'hF0, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_OVR0=8'h00, SC_OVR1=8'hFF
  - decoder state enum
  - key_event_t struct {repeat, ext, make, code[7:0]} (11 bits)
- One sub-module: key_evt_fifo, a synchronous FWFT FIFO of key_event_t, parameterised by depth, with async active-high reset.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> events {make,1C,ext0}, then {break,1C,ext0}; press_count=1; held_valid goes 1 then 0.
- Bytes E0, 75, E0, F0, 75 -> {make,75,ext1}, {break,75,ext1}; no event emitted for any prefix byte.
- REPEAT_EN=0, bytes 1B, 1B, 1B, F0, 1B -> exactly 2 events (make, break); press_count=1. With REPEAT_EN=1 -> 4 events, the middle two with repeat=1.
- evt_ready=0, feed 5 make codes 15, 1D, 24, 2D, 2C -> rx_ready drops after the 4th event; the 5th byte stalls until one pop, then is accepted; events pop in order.
- Bytes AA, FA, FF, 1C -> a single {make,1C} event; overrun=1 and stays set until reset.
- Send F0, assert reset for 1 cycle, then send 1C -> {make,1C} (prefix discarded); press_count=1.
